hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 44 ++++
 rtl/hazard_scoreboard_operand_check.sv | 21 ++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, scoreboard entry type and helper functions for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned REG_W   = $clog2(NREG);
  localparam int unsigned NSTAGE  = 3;
  localparam int unsigned MAX_LAT = 4;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned FSEL_W  = $clog2(NSTAGE + 1);

  typedef logic [FSEL_W-1:0] fwd_sel_t;
  typedef logic [LAT_W-1:0]  lat_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  // One pending register write: cycles until forwardable and the stage holding it.
  typedef struct packed {
    logic     valid;
    lat_t     cnt;
    fwd_sel_t age;
  } sb_entry_t;

  // Latency 0 behaves like a single-cycle ALU op; anything above MAX_LAT saturates.
  function automatic lat_t lat_clamp(input lat_t lat);
    lat_t res;
    res = lat;
    if (lat == '0) begin
      res = LAT_W'(1);
    end else if (32'(lat) > MAX_LAT) begin
      res = LAT_W'(MAX_LAT);
    end
    return res;
  endfunction

  // Stage that holds the producer once the consumer reaches EX; 0 selects the regfile.
  function automatic fwd_sel_t src_fwd(input sb_entry_t e);
    fwd_sel_t sel;
    sel = '0;
    if (e.valid && ((32'(e.age) + 32'd1) <= NSTAGE)) begin
      sel = FSEL_W'(32'(e.age) + 32'd1);
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_operand_check.sv
// Per-source RAW stall and bypass select from the producer's scoreboard entry.
module hazard_scoreboard_operand_check
  import hazard_scoreboard_pkg::*;
(
  input  sb_entry_t entry,
  input  logic      src_used,
  output logic      raw_stall,
  output fwd_sel_t  fwd_sel
);

  // Unused or x0 sources never stall and always read the regfile.
  always_comb begin
    raw_stall = 1'b0;
    fwd_sel   = '0;
    if (src_used) begin
      raw_stall = entry.valid && (entry.cnt > LAT_W'(1));
      fwd_sel   = src_fwd(entry);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard: issue gating, bypass selects and pipeline hold.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             issue_valid_i,
  input  logic [REG_W-1:0] issue_rs1_i,
  input  logic             issue_rs1_use_i,
  input  logic [REG_W-1:0] issue_rs2_i,
  input  logic             issue_rs2_use_i,
  input  logic [REG_W-1:0] issue_rd_i,
  input  logic             issue_rd_wr_i,
  input  logic [LAT_W-1:0] issue_lat_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             issue_ready_o,
  output logic             stall_o,
  output fwd_sel_t         fwd_a_o,
  output fwd_sel_t         fwd_b_o,
  output logic [NREG-1:0]  busy_o
);

  sb_entry_t [NREG-1:0] sb_q;
  sb_entry_t [NREG-1:0] sb_d;

  logic      rs1_act;
  logic      rs2_act;
  logic      rs1_raw;
  logic      rs2_raw;
  logic      waw;
  logic      stall;
  logic      ready;
  sb_entry_t rd_entry;

  assign rs1_act  = issue_rs1_use_i && (issue_rs1_i != '0);
  assign rs2_act  = issue_rs2_use_i && (issue_rs2_i != '0);
  assign rd_entry = sb_q[issue_rd_i];

  hazard_scoreboard_operand_check u_chk_a (
    .entry     (sb_q[issue_rs1_i]),
    .src_used  (rs1_act),
    .raw_stall (rs1_raw),
    .fwd_sel   (fwd_a_o)
  );

  hazard_scoreboard_operand_check u_chk_b (
    .entry     (sb_q[issue_rs2_i]),
    .src_used  (rs2_act),
    .raw_stall (rs2_raw),
    .fwd_sel   (fwd_b_o)
  );

  // A younger write must not become visible before an older one to the same rd.
  always_comb begin
    waw = 1'b0;
    if (issue_rd_wr_i && (issue_rd_i != '0) && rd_entry.valid) begin
      waw = (issue_lat_i < rd_entry.cnt);
    end
  end

  // Zero-cycle issue decision; both outputs are forced low while reset is asserted.
  always_comb begin
    stall = rstn_i && ((issue_valid_i && (rs1_raw || rs2_raw || waw)) || hold_i);
    ready = rstn_i && issue_valid_i && !stall && !flush_i;
  end

  assign stall_o       = stall;
  assign issue_ready_o = ready;

  // Advance every pending write one stage; an accepted write overrides its entry.
  always_comb begin
    sb_d = sb_q;
    if (!hold_i) begin
      for (int i = 1; i < NREG; i++) begin
        if (sb_q[REG_W'(i)].valid) begin
          if (32'(sb_q[REG_W'(i)].age) >= NSTAGE) begin
            sb_d[REG_W'(i)] = '0;
          end else begin
            sb_d[REG_W'(i)].age = sb_q[REG_W'(i)].age + FSEL_W'(1);
            sb_d[REG_W'(i)].cnt = (sb_q[REG_W'(i)].cnt == '0) ? '0
                                : sb_q[REG_W'(i)].cnt - LAT_W'(1);
          end
        end
      end
      if (ready && issue_rd_wr_i && (issue_rd_i != '0)) begin
        sb_d[issue_rd_i] = '{valid: 1'b1, cnt: lat_clamp(issue_lat_i), age: FSEL_W'(1)};
      end
    end
  end

  // Scoreboard state; reset drops every pending write immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Debug view of which registers have a write in flight.
  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_o[REG_W'(i)] = sb_q[REG_W'(i)].valid;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             issue_valid = 1'b0;
  logic [REG_W-1:0] rs1 = '0;
  logic             rs1_use = 1'b0;
  logic [REG_W-1:0] rs2 = '0;
  logic             rs2_use = 1'b0;
  logic [REG_W-1:0] rd = '0;
  logic             rd_wr = 1'b0;
  logic [LAT_W-1:0] lat = '0;
  logic             hold = 1'b0;
  logic             flush = 1'b0;
  logic             issue_ready;
  logic             stall;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic [NREG-1:0]  busy;

  hazard_scoreboard dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .issue_valid_i   (issue_valid),
    .issue_rs1_i     (rs1),
    .issue_rs1_use_i (rs1_use),
    .issue_rs2_i     (rs2),
    .issue_rs2_use_i (rs2_use),
    .issue_rd_i      (rd),
    .issue_rd_wr_i   (rd_wr),
    .issue_lat_i     (lat),
    .hold_i          (hold),
    .flush_i         (flush),
    .issue_ready_o   (issue_ready),
    .stall_o         (stall),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ready;
    logic            stall;
    fwd_sel_t        fa;
    fwd_sel_t        fb;
    logic [NREG-1:0] busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    mc_stalls = 0;

  task automatic check_one(input string tag, input string field,
                           input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
    end
  endtask

  task automatic compare_next();
    exp_t  e;
    string t;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=nonzero", exp_q.size());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_one(t, "issue_ready", 32'(issue_ready), 32'(e.ready));
      check_one(t, "stall",       32'(stall),       32'(e.stall));
      check_one(t, "fwd_a",       32'(fwd_a),       32'(e.fa));
      check_one(t, "fwd_b",       32'(fwd_b),       32'(e.fb));
      check_one(t, "busy",        32'(busy),        32'(e.busy));
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, queue its expectation, check 1 time unit later.
  task automatic step(input string tag, input int rst, input int v,
                      input int r1, input int u1, input int r2, input int u2,
                      input int d, input int wr, input int l, input int hd, input int fl,
                      input int e_ready, input int e_stall, input int e_fa, input int e_fb,
                      input logic [31:0] e_busy);
    exp_t e;
    @(negedge clk);
    rstn        = (rst != 0);
    issue_valid = (v != 0);
    rs1         = REG_W'(r1);
    rs1_use     = (u1 != 0);
    rs2         = REG_W'(r2);
    rs2_use     = (u2 != 0);
    rd          = REG_W'(d);
    rd_wr       = (wr != 0);
    lat         = LAT_W'(l);
    hold        = (hd != 0);
    flush       = (fl != 0);
    e.ready = (e_ready != 0);
    e.stall = (e_stall != 0);
    e.fa    = FSEL_W'(e_fa);
    e.fb    = FSEL_W'(e_fb);
    e.busy  = NREG'(e_busy);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    compare_next();
  endtask

  initial begin
    // reset state: valid issue is refused while reset is held
    step("rst_hold",   0, 1,  1,1,  0,0,  2,1,1,  0,0,  0,0,0,0, 32'h0);
    step("post_rst",   1, 1,  1,1,  0,0,  0,0,1,  0,0,  1,0,0,0, 32'h0);
    // ALU back-to-back
    step("alu_prod",   1, 1,  0,0,  0,0,  5,1,1,  0,0,  1,0,0,0, 32'h0);
    step("alu_ex_a",   1, 1,  5,1,  0,0,  0,0,1,  0,0,  1,0,2,0, 32'h20);
    step("alu_mem_b",  1, 1,  0,0,  5,1,  0,0,1,  0,0,  1,0,0,3, 32'h20);
    step("alu_wb",     1, 1,  5,1,  5,1,  0,0,1,  0,0,  1,0,0,0, 32'h20);
    step("alu_clear",  1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h0);
    // load-use
    step("ld_prod",    1, 1,  0,0,  0,0,  7,1,2,  0,0,  1,0,0,0, 32'h0);
    step("ld_stall",   1, 1,  7,1,  0,0,  0,0,1,  0,0,  0,1,2,0, 32'h80);
    step("ld_go",      1, 1,  7,1,  0,0,  0,0,1,  0,0,  1,0,3,0, 32'h80);
    step("ld_drain",   1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h80);
    // multi-cycle producer with a 3-cycle hold
    step("mc_prod",    1, 1,  0,0,  0,0,  9,1,4,  0,0,  1,0,0,0, 32'h0);
    step("mc_stall0",  1, 1,  9,1,  0,0,  0,0,1,  0,0,  0,1,2,0, 32'h200);
    if (stall) mc_stalls++;
    for (int k = 0; k < 3; k++) begin
      step("mc_hold",  1, 1,  9,1,  0,0,  0,0,1,  1,0,  0,1,3,0, 32'h200);
      if (stall) mc_stalls++;
    end
    step("mc_stall1",  1, 1,  9,1,  0,0,  0,0,1,  0,0,  0,1,3,0, 32'h200);
    if (stall) mc_stalls++;
    step("mc_stall2",  1, 1,  9,1,  0,0,  0,0,1,  0,0,  0,1,0,0, 32'h200);
    if (stall) mc_stalls++;
    step("mc_go",      1, 1,  9,1,  0,0,  0,0,1,  0,0,  1,0,0,0, 32'h0);
    if (stall) mc_stalls++;
    check_one("mc", "stall_cycles", 32'(mc_stalls), 32'd6);
    // WAW ordering
    step("waw_old",    1, 1,  0,0,  0,0,  3,1,4,  0,0,  1,0,0,0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step("waw_stall", 1, 1, 0,0,  0,0,  3,1,1,  0,0,  0,1,0,0, 32'h8);
    end
    step("waw_go",     1, 1,  0,0,  0,0,  3,1,1,  0,0,  1,0,0,0, 32'h0);
    step("waw_young",  1, 1,  3,1,  0,0,  0,0,1,  0,0,  1,0,2,0, 32'h8);
    step("waw_dr1",    1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h8);
    step("waw_dr2",    1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h8);
    // x0 and flush
    step("x0_wr",      1, 1,  0,1,  0,1,  0,1,1,  0,0,  1,0,0,0, 32'h0);
    step("x0_rd",      1, 1,  0,1,  0,0,  0,0,1,  0,0,  1,0,0,0, 32'h0);
    step("flush_wr",   1, 1,  0,0,  0,0,  4,1,1,  0,1,  0,0,0,0, 32'h0);
    step("flush_none", 1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h0);
    step("pre_flush",  1, 1,  0,0,  0,0,  6,1,2,  0,0,  1,0,0,0, 32'h0);
    step("flush_keep", 1, 1,  0,0,  0,0,  8,1,1,  0,1,  0,0,0,0, 32'h40);
    step("post_flush", 1, 1,  6,1,  0,0,  0,0,1,  0,0,  1,0,3,0, 32'h40);
    step("flush_dr",   1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h40);
    // latency clamping
    step("lat0",       1, 1,  0,0,  0,0, 10,1,0,  0,0,  1,0,0,0, 32'h0);
    step("lat0_use",   1, 1, 10,1,  0,0,  0,0,1,  0,0,  1,0,2,0, 32'h400);
    step("lat_sat",    1, 1,  0,0,  0,0, 11,1,7,  0,0,  1,0,0,0, 32'h400);
    step("lat_sat_waw",1, 1,  0,0,  0,0, 11,1,5,  0,0,  1,0,0,0, 32'hC00);
    step("lat_dr",     1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h800);
    // reset mid-flight
    step("rf_a",       1, 1,  0,0,  0,0, 12,1,4,  0,0,  1,0,0,0, 32'h800);
    step("rf_b",       1, 1,  0,0,  0,0, 13,1,4,  0,0,  1,0,0,0, 32'h1800);
    step("rf_c",       1, 1,  0,0,  0,0, 14,1,1,  0,0,  1,0,0,0, 32'h3000);
    step("rf_pend",    1, 0,  0,0,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h7000);
    step("rf_reset",   0, 1, 13,1,  0,0,  0,0,1,  0,0,  0,0,0,0, 32'h0);
    step("rf_consume", 1, 1, 13,1, 14,1,  0,0,1,  0,0,  1,0,0,0, 32'h0);
    // hold stalls even with no instruction presented
    step("hold_idle",  1, 0,  0,0,  0,0,  0,0,1,  1,0,  0,1,0,0, 32'h0);
    check_one("end", "queue_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
